// File: rtl/direction_cmd_queue.sv
// rtl/direction_cmd_queue.sv - button sync/debounce/edge/encode feeding a small direction command FIFO.
// Optional macro REVERSE_FILTER_EN drops pushes that directly reverse the reference direction.
module direction_cmd_queue #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int DEPTH           = 4,
  parameter int PTR_W           = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_pause,
  input  logic             pop,
  output logic [2:0]       cmd,
  output logic             cmd_valid,
  output logic [PTR_W:0]   count,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);

  // Bit order: 0 up, 1 down, 2 left, 3 right, 4 pause.
  logic [4:0] btn_raw;
  assign btn_raw = {btn_pause, btn_right, btn_left, btn_down, btn_up};

  logic [4:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic [4:0]       deb_q, deb_d, deb_dly_q, deb_dly_d, ev_q, ev_d;
  logic [CNT_W-1:0] cnt_q [5];
  logic [CNT_W-1:0] cnt_d [5];
  logic [2:0]       code_q, code_d;
  logic [2:0]       mem_q [DEPTH];
  logic [2:0]       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             overflow_q, overflow_d;

  logic [PTR_W-1:0] tail_ptr;
  logic [2:0]       last_code;
  logic             nonempty, full, discard, push_req, pop_ok, push_ok;

  assign tail_ptr  = wr_ptr_q - PTR_W'(1);
  assign last_code = mem_q[tail_ptr];
  assign nonempty  = (count_q != '0);
  assign full      = (count_q == FULL_CNT);

`ifdef REVERSE_FILTER_EN
  logic [2:0] last_pop_q, last_pop_d;
  logic [2:0] ref_code;
  logic       is_reverse;

  // With an empty queue the last consumed direction is the reference.
  assign ref_code   = nonempty ? last_code : last_pop_q;
  assign is_reverse = (code_q == 3'd1 && ref_code == 3'd2) || (code_q == 3'd2 && ref_code == 3'd1) ||
                      (code_q == 3'd3 && ref_code == 3'd4) || (code_q == 3'd4 && ref_code == 3'd3);
  assign discard    = (nonempty && code_q == last_code) || is_reverse;
`else
  assign discard    = nonempty && (code_q == last_code);
`endif

  assign push_req = (code_q != 3'd0) && !discard;
  assign pop_ok   = pop && nonempty;
  assign push_ok  = push_req && (!full || pop_ok);

  always_comb begin
    sync1_d   = btn_raw;
    sync2_d   = sync1_q;
    deb_d     = deb_q;
    deb_dly_d = deb_q;
    ev_d      = deb_q & ~deb_dly_q;
    for (int i = 0; i < 5; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_MAX) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end

    code_d = 3'd0;
    if (ev_q[4])      code_d = 3'd5;
    else if (ev_q[0]) code_d = 3'd1;
    else if (ev_q[1]) code_d = 3'd2;
    else if (ev_q[2]) code_d = 3'd3;
    else if (ev_q[3]) code_d = 3'd4;
  end

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = push_req && full && !pop_ok;
`ifdef REVERSE_FILTER_EN
    last_pop_d = last_pop_q;
`endif
    if (push_ok) begin
      mem_d[wr_ptr_q] = code_q;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
`ifdef REVERSE_FILTER_EN
      last_pop_d = mem_q[rd_ptr_q];
`endif
    end
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_dly_q  <= '0;
      ev_q       <= '0;
      code_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
`ifdef REVERSE_FILTER_EN
      last_pop_q <= 3'd0;
`endif
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_dly_q  <= deb_dly_d;
      ev_q       <= ev_d;
      code_q     <= code_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
`ifdef REVERSE_FILTER_EN
      last_pop_q <= last_pop_d;
`endif
    end
  end

  // Storage needs no reset: the head is masked while the queue is empty.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
  end

  assign cmd       = nonempty ? mem_q[rd_ptr_q] : 3'd0;
  assign cmd_valid = nonempty;
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_direction_cmd_queue.sv
// tb/tb_direction_cmd_queue.sv - directed self-checking bench for direction_cmd_queue (DEBOUNCE_CYCLES=4, DEPTH=4).
module tb_direction_cmd_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] btn;
  logic       pop;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic [2:0] count;
  logic       overflow;

  int passed = 0;
  int total  = 0;
  int ovf_cnt = 0;

  always #5 clk = ~clk;

  direction_cmd_queue #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(4),
    .DEPTH(4),
    .PTR_W(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_up(btn[0]),
    .btn_down(btn[1]),
    .btn_left(btn[2]),
    .btn_right(btn[3]),
    .btn_pause(btn[4]),
    .pop(pop),
    .cmd(cmd),
    .cmd_valid(cmd_valid),
    .count(count),
    .overflow(overflow)
  );

  // Overflow is a one-cycle pulse; count pulses mid-cycle.
  always @(negedge clk) if (overflow === 1'b1) ovf_cnt++;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Press long enough to register, then release and let the release settle.
  task automatic press(input logic [4:0] mask);
    btn = mask;
    tick(10);
    btn = 5'b0;
    tick(8);
  endtask

  task automatic do_pop();
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    btn   = 5'b0;
    pop   = 1'b0;
    tick(2);
    reset = 1'b0;
    check("rst_count", count, 0);
    check("rst_cmd", cmd, 0);
    check("rst_valid", cmd_valid, 0);
    check("rst_overflow", overflow, 0);

    // 1: held up press, latency 9
    btn[0] = 1'b1;
    tick(8);
    check("t1_valid_at_8", cmd_valid, 0);
    tick();
    check("t1_valid_at_9", cmd_valid, 1);
    check("t1_cmd", cmd, 1);
    check("t1_count", count, 1);
    tick(11);
    check("t1_held_count", count, 1);
    btn[0] = 1'b0;
    tick(10);
    check("t1_release_count", count, 1);
    do_pop();
    check("t1_pop_count", count, 0);
    check("t1_pop_cmd", cmd, 0);

    // 2: glitch shorter than debounce
    btn[2] = 1'b1;
    tick(2);
    btn[2] = 1'b0;
    tick(12);
    check("t2_count", count, 0);
    check("t2_cmd", cmd, 0);

    // 3: fill, overflow, drain
    ovf_cnt = 0;
    press(5'b00001);
    press(5'b00100);
    press(5'b00010);
    press(5'b01000);
    check("t3_full_count", count, 4);
    check("t3_no_ovf_yet", ovf_cnt, 0);
    press(5'b10000);
    check("t3_ovf_pulses", ovf_cnt, 1);
    check("t3_count_after_ovf", count, 4);
    check("t3_pop0", cmd, 1);
    do_pop();
    check("t3_pop1", cmd, 3);
    do_pop();
    check("t3_pop2", cmd, 2);
    do_pop();
    check("t3_pop3", cmd, 4);
    do_pop();
    check("t3_empty_cmd", cmd, 0);
    check("t3_empty_valid", cmd_valid, 0);

    // 4: simultaneous up and pause
    press(5'b10001);
    check("t4_count", count, 1);
    check("t4_cmd", cmd, 5);
    do_pop();
    check("t4_drained", count, 0);

    // 5: push+pop when full
    press(5'b00001);
    press(5'b00100);
    press(5'b10000);
    press(5'b00001);
    check("t5_full", count, 4);
    ovf_cnt = 0;
    btn[2] = 1'b1;
    tick(8);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    check("t5_count_same", count, 4);
    tick();
    check("t5_no_ovf", ovf_cnt, 0);
    btn[2] = 1'b0;
    tick(10);
    check("t5_head", cmd, 3);
    do_pop();
    check("t5_e1", cmd, 5);
    do_pop();
    check("t5_e2", cmd, 1);
    do_pop();
    check("t5_tail", cmd, 3);
    do_pop();
    check("t5_empty", count, 0);
    do_pop();
    check("t5_pop_empty_count", count, 0);
    check("t5_pop_empty_cmd", cmd, 0);

    // 6: right then left, then reset with queued entries
    press(5'b10000);
    do_pop();
    press(5'b01000);
    press(5'b00100);
    press(5'b00001);
`ifdef REVERSE_FILTER_EN
    check("t6_count", count, 2);
    check("t6_head", cmd, 4);
`else
    check("t6_count", count, 3);
    check("t6_head", cmd, 4);
    do_pop();
    check("t6_second", cmd, 3);
    press(5'b00010);
    check("t6_refill", count, 3);
`endif
    reset = 1'b1;
    tick();
    check("t6_rst_count", count, 0);
    check("t6_rst_cmd", cmd, 0);
    check("t6_rst_valid", cmd_valid, 0);
    reset = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/direction_cmd_queue.md
Name: direction_cmd_queue

Overview:
- Upstream stage of the snake movement FSM: conditions the five raw push-buttons (up, down, left, right, pause) and queues them as direction commands.
- Each button is synchronised and debounced, and its rising edge is encoded into a 3-bit command.
- Commands are buffered in a small FIFO. The FSM pops one command per movement tick, so fast key sequences between ticks are not lost.
- Command encoding: 0 none, 1 up, 2 down, 3 left, 4 right, 5 pause.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required before a debounced level changes.
- CNT_W, 20: width of each debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- DEPTH, 4: FIFO entries. Power of two, range 2..16.
- PTR_W, 2: log2(DEPTH).

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- btn_up, in, 1: raw asynchronous button input.
- btn_down, in, 1: raw asynchronous button input.
- btn_left, in, 1: raw asynchronous button input.
- btn_right, in, 1: raw asynchronous button input.
- btn_pause, in, 1: raw asynchronous button input.
- pop, in, 1: single-cycle pulse from the FSM; consumes the head entry.
- cmd, out, 3: head command; 0 when the FIFO is empty.
- cmd_valid, out, 1: high when the FIFO is non-empty.
- count, out, PTR_W+1: number of stored entries.
- overflow, out, 1: one-cycle pulse when a command is dropped because the FIFO is full.

Behaviour:
- Reset (synchronous, active-high):
  - Synchronisers, debounced levels and debounce counters are cleared.
  - FIFO pointers are zeroed.
  - Outputs: cmd=0, cmd_valid=0, count=0, overflow=0.
  - Reset asserted mid-operation discards all queued commands on the next edge.
- Synchronisation: each button passes through a 2-flop synchroniser. Raw-to-sync latency is 2 cycles.
- Debounce, per button (stable level `deb`, counter `cnt`):
  - If sync equals deb: cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - When cnt reaches DEBOUNCE_CYCLES-1 while sync still differs: deb <= sync and cnt <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES never changes deb.
- Edge detect: `ev_x` is high for exactly one cycle after deb goes 0->1. Releases (1->0) generate no event.
- Encode:
  - Priority when several events fire in the same cycle: pause > up > down > left > right.
  - Only the highest-priority code is offered; the others are discarded silently.
  - Encoded code is registered, giving a 1-cycle push latency.
- Duplicate suppression: a push is discarded (no overflow pulse) if the FIFO is non-empty and the code equals the most recently written entry (tail-1).
- FIFO (circular buffer, wr_ptr/rd_ptr of PTR_W bits that wrap modulo DEPTH, count of PTR_W+1 bits):
  - Push when not full: mem[wr_ptr] <= code, wr_ptr+1, count+1.
  - Push when full without pop: write dropped, overflow=1 for one cycle.
  - Pop when non-empty: rd_ptr+1, count-1.
  - Pop when empty: ignored.
  - Push and pop together when full: both performed, count unchanged, no overflow.
  - Push and pop together when empty: push performed, pop ignored (no bypass), count=1.
- Outputs: cmd = mem[rd_ptr] when count != 0, else 0. cmd and cmd_valid update on the clock edge after any push or pop.
- Total latency, raw press to cmd_valid: 2 (synchroniser) + DEBOUNCE_CYCLES + 1 (edge) + 1 (encode) + 1 (write) cycles, measured from a clean edge.

Optional Feature:
- Macro: REVERSE_FILTER_EN.
- Defined:
  - A push is also discarded when it is the direct reverse of the most recently written direction: up/down, left/right.
  - When the FIFO is empty, the reference is instead the last popped direction, held in a register that reset clears to 0 (no filtering).
  - Pause (5) is never filtered.
  - Discards produce no overflow pulse.
- Undefined: all direction codes are queued; only duplicate suppression applies.

Test Plan (DEBOUNCE_CYCLES=4, DEPTH=4):
1. Reset, then hold btn_up high 20 cycles -> cmd_valid rises 9 cycles after btn_up; cmd=1, count=1; no second push while held.
2. Pulse btn_left high 2 cycles -> no event, count stays 0, cmd=0.
3. Press up, left, down, right, pause in sequence with no pops -> count=4, FIFO holds 1,3,2,4; pause push drops with a single overflow pulse; then 4 pops yield 1,3,2,4, then cmd=0, cmd_valid=0.
4. btn_up and btn_pause rise in the same cycle -> single entry 5; count=1.
5. FIFO full (count=4) with pop and a new push (left) in the same cycle -> count stays 4, no overflow, new tail=3; also: pop pulse while empty -> count stays 0.
6. With REVERSE_FILTER_EN: press right then left -> only 4 queued. Without the macro -> 4,3 queued. Assert reset with 3 entries -> count=0, cmd=0 next cycle.
